// File: rtl/rr_ctrl_pkg.sv
// Shared types and helpers for the round-robin grant controller.
// Optional feature macro used by the controller: RR_HOLD_TIMEOUT_EN.
package rr_ctrl_pkg;

    // Controller state: waiting for a request, or holding a grant
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Widest requester vector the one-hot helper can represent
    localparam int MAX_REQ = 32;

    // Index width for n entries; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot vector with bit idx set, limited to the first n positions
    function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
        logic [MAX_REQ-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_REQ) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping modulo the requester count. The request vector is duplicated so
// the wrap becomes a plain lowest-set-bit search over the masked double word.
module rr_priority_pick
    import rr_ctrl_pkg::*;
#(
    parameter int requesters = 4
) (
    input  logic [requesters-1:0]            request,
    input  logic [idx_width(requesters)-1:0] ptr,
    output logic                             found,
    output logic [idx_width(requesters)-1:0] pick
);

    localparam int IW = idx_width(requesters);

    logic [2*requesters-1:0] dbl;
    logic [2*requesters-1:0] masked;
    int                      first;

    // Mask everything below ptr in the doubled vector, then take the lowest set bit
    always_comb begin
        dbl    = {request, request};
        masked = '0;
        first  = 0;
        for (int i = 0; i < 2 * requesters; i++) begin
            masked[i] = dbl[i] & (i >= int'(ptr));
        end
        for (int i = 2 * requesters - 1; i >= 0; i--) begin
            if (masked[i]) begin
                first = i;
            end
        end
        found = |request;
        pick  = IW'(first % requesters);
    end

endmodule

// File: rtl/rr_grant_controller.sv
// Round-robin owner controller for one shared multi-cycle resource.
// A grant is held until the owner pulses done or drops its request; every
// grant is followed by one idle cycle with chosen all zero.
// Optional macro RR_HOLD_TIMEOUT_EN: bounds each grant to MAX_HOLD cycles and
// pulses timeout when a grant is revoked. Without it timeout is tied low.
module rr_grant_controller
    import rr_ctrl_pkg::*;
#(
    parameter int requesters = 4,
    parameter int MAX_HOLD   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [requesters-1:0]            request,
    input  logic [requesters-1:0]            done,
    output logic [requesters-1:0]            chosen,
    output logic [idx_width(requesters)-1:0] owner,
    output logic                             busy,
    output logic                             timeout
);

    localparam int IW = idx_width(requesters);

    state_t                 state;
    logic [IW-1:0]          ptr;
    logic                   found;
    logic [IW-1:0]          pick;
    logic [IW-1:0]          next_ptr;
    logic [MAX_REQ-1:0]     oh_wide;
    logic [requesters-1:0]  grant_oh;
    logic                   rel_now;
    logic                   unused_oh_hi;

    rr_priority_pick #(
        .requesters (requesters)
    ) u_pick (
        .request (request),
        .ptr     (ptr),
        .found   (found),
        .pick    (pick)
    );

    // One-hot of the winner, trimmed to the requester count; the upper bits
    // are always zero and are only folded here so they count as read
    assign oh_wide      = onehot(int'(pick), requesters);
    assign grant_oh     = oh_wide[requesters-1:0];
    assign unused_oh_hi = ^oh_wide;

    // Pointer moves one past the winner and wraps from the last requester to 0
    assign next_ptr = (int'(pick) == requesters - 1) ? '0 : pick + IW'(1);

    // Only the current owner can end its grant: a done pulse or a dropped request
    assign rel_now = done[owner] | ~request[owner];

`ifdef RR_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD) + 1;

    logic [HW-1:0] hold_cnt;
    logic          hold_expire;

    // Counts BUSY cycles; sits at zero while idle so each grant starts from 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // Last permitted hold cycle; revocation happens on the following edge
    assign hold_expire = (hold_cnt == HW'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    // Grant FSM: arbitrate in IDLE, hold the owner in BUSY until release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            chosen <= '0;
            busy   <= 1'b0;
`ifdef RR_HOLD_TIMEOUT_EN
            timeout <= 1'b0;
`endif
        end else begin
`ifdef RR_HOLD_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        chosen <= grant_oh;
                        owner  <= pick;
                        busy   <= 1'b1;
                        ptr    <= next_ptr;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (rel_now) begin
                        chosen <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
`ifdef RR_HOLD_TIMEOUT_EN
                    else if (hold_expire) begin
                        chosen  <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end
`endif
                end
                default: begin
                    chosen <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_controller.sv
// Directed bench for rr_grant_controller (4 requesters, MAX_HOLD=4).
module tb_rr_grant_controller;

    logic       clk;
    logic       reset;
    logic [3:0] request;
    logic [3:0] done;
    logic [3:0] chosen;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_grant_controller #(
        .requesters (4),
        .MAX_HOLD   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .request (request),
        .done    (done),
        .chosen  (chosen),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;

        // Reset held with all requests asserted
        reset   = 1'b1;
        request = 4'b1111;
        done    = 4'b0000;
        step(); step(); step();
        check("reset_chosen",  chosen,  0);
        check("reset_busy",    busy,    0);
        check("reset_owner",   owner,   0);
        check("reset_timeout", timeout, 0);

        // Rotation between requesters 0 and 2
        request = 4'b0101;
        reset   = 1'b0;
        step();
        check("rot_g0_c1",    chosen, 4'b0001);
        check("rot_g0_owner", owner,  0);
        check("rot_g0_busy",  busy,   1);
        step();
        check("rot_g0_c2", chosen, 4'b0001);
        done = 4'b0001;
        step();
        check("rot_gap0",      chosen, 4'b0000);
        check("rot_gap0_busy", busy,   0);
        done = 4'b0000;
        step();
        check("rot_g2_c1",    chosen, 4'b0100);
        check("rot_g2_owner", owner,  2);
        step();
        check("rot_g2_c2", chosen, 4'b0100);
        done = 4'b0100;
        step();
        check("rot_gap1", chosen, 4'b0000);
        done = 4'b0000;
        step();
        check("rot_g0_again", chosen, 4'b0001);
        request = 4'b0000;
        step();
        check("rot_drop_idle", busy, 0);

        // Async reset pulse between edges to restart the pointer at 0
        #2 reset = 1'b1;
        #2 reset = 1'b0;

        // Full contention, one cycle per grant, pointer wraps 3 -> 0
        request = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("full_grant%0d", i), chosen, seq[i]);
            check($sformatf("full_busy%0d", i),  busy,   1);
            done = seq[i];
            step();
            check($sformatf("full_gap%0d", i), chosen, 4'b0000);
            done = 4'b0000;
        end

        // Release by drop; non-owner done and request changes are ignored
        request = 4'b0010;
        step();
        check("drop_grant", chosen, 4'b0010);
        check("drop_owner", owner,  1);
        done    = 4'b0100;
        request = 4'b1010;
        step();
        check("drop_nonowner_done", chosen, 4'b0010);
        check("drop_still_busy",    busy,   1);
        done    = 4'b0000;
        request = 4'b0000;
        step();
        check("drop_release", chosen, 4'b0000);
        check("drop_busy",    busy,   0);

        // Mid-grant asynchronous reset
        request = 4'b1000;
        step();
        check("mid_grant", chosen, 4'b1000);
        check("mid_owner", owner,  3);
        #2 reset = 1'b1;
        #1;
        check("mid_async_chosen", chosen, 4'b0000);
        check("mid_async_busy",   busy,   0);
        request = 4'b1001;
        #1 reset = 1'b0;
        step();
        check("mid_after_grant", chosen, 4'b0001);
        check("mid_after_owner", owner,  0);
        request = 4'b0000;
        step();
        check("mid_after_idle", chosen, 4'b0000);

        // Hold behaviour for a requester that never signals done
        request = 4'b0010;
`ifdef RR_HOLD_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("to_hold%0d", c),    chosen,  4'b0010);
            check($sformatf("to_quiet%0d", c),   timeout, 0);
        end
        step();
        check("to_revoked", chosen,  4'b0000);
        check("to_pulse",   timeout, 1);
        step();
        check("to_regrant",      chosen,  4'b0010);
        check("to_pulse_clear",  timeout, 0);
        step(); step(); step();
        check("to_prec_hold", chosen, 4'b0010);
        done = 4'b0010;
        step();
        check("to_prec_release", chosen,  4'b0000);
        check("to_prec_no_pulse", timeout, 0);
        done = 4'b0000;
`else
        for (int c = 0; c < 52; c++) begin
            step();
            check($sformatf("hold_chosen%0d", c),  chosen,  4'b0010);
            check($sformatf("hold_timeout%0d", c), timeout, 0);
        end
        done = 4'b0010;
        step();
        check("hold_release", chosen, 4'b0000);
        done = 4'b0000;
`endif
        request = 4'b0000;
        step();
        check("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
